// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types and constants for the memory responder slice.
// Word-granular (64-bit) storage with 8 byte lanes.
package ysyx_22050612_mem_pkg;

  localparam int WORD_BYTES = 8;
  localparam int MASK_W     = 8;
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22050612_mem_responder_if.sv
// Request/response valid-ready channels between the load/store initiator and the responder.
// master = requester side, slave = responder side.
interface ysyx_22050612_mem_responder_if;
  import ysyx_22050612_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/ysyx_22050612_mem_array.sv
// Single-port byte-masked RAM, one 64-bit word per index; registered read.
// Read data holds its value until the next enabled read.
module ysyx_22050612_mem_array
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [MASK_W-1:0]     wmask,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [1<<DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= merge_bytes(mem[idx], wdata, wmask);
      else    rdata_q  <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_22050612_mem_responder.sv
// Memory responder: one outstanding request, response LATENCY cycles after acceptance.
// Request side stalls (req_ready=0) until the response handshake; response held stable under backpressure.
module ysyx_22050612_mem_responder
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter int                LATENCY    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050612_mem_responder_if.slave  bus
);

  localparam logic [ADDR_W-1:0] WIN_BYTES = 64'(WORD_BYTES) << DEPTH_LOG2;
  localparam logic [3:0]        LAT_M1    = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_rd_q, resp_rd_d;

  logic              cur_wen;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [MASK_W-1:0] cur_wmask;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              access;
  logic [DATA_W-1:0] arr_rdata;

  // With LATENCY=1 the access happens on the acceptance edge, so it must see the live bus.
  always_comb begin
    if (state_q == IDLE) begin
      cur_wen   = bus.req_wen;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_wmask = bus.req_wmask;
    end else begin
      cur_wen   = wen_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_wmask = wmask_q;
    end
  end

  assign offset   = cur_addr - BASE_ADDR;
  assign in_range = (cur_addr >= BASE_ADDR) && (offset < WIN_BYTES);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    resp_err_d = resp_err_q;
    resp_rd_d  = resp_rd_q;
    access     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d    = IDLE;
          resp_err_d = 1'b0;
          resp_rd_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      resp_err_d = !in_range;
      resp_rd_d  = in_range && !cur_wen;
    end
  end

  assign req_ready_d  = (state_d == IDLE);
  assign resp_valid_d = (state_d == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  // Gating with rst keeps a reset on the access edge from committing a write.
  ysyx_22050612_mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (access && in_range && !rst),
    .we    (cur_wen),
    .idx   (offset[DEPTH_LOG2+2:3]),
    .wdata (cur_wdata),
    .wmask (cur_wmask),
    .rdata (arr_rdata)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Bench for the memory responder: three instances (LATENCY 2, 1, 4) with a queue scoreboard per instance.
module tb_ysyx_22050612_mem_responder;
  import ysyx_22050612_mem_pkg::*;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TOP  = BASE + (64'd8 << 10);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        t_req_valid  [3];
  logic        t_req_wen    [3];
  logic [63:0] t_req_addr   [3];
  logic [63:0] t_req_wdata  [3];
  logic [7:0]  t_req_wmask  [3];
  logic        t_resp_ready [3];
  wire         o_req_ready  [3];
  wire         o_resp_valid [3];
  wire  [63:0] o_resp_rdata [3];
  wire         o_resp_err   [3];

  exp_t exp_q    [3][$];
  int   acc_q    [3][$];
  int   acc_hist [3][$];
  int   hs_edge  [3];
  logic prev_rv  [3];

  ysyx_22050612_mem_responder_if b2 ();
  ysyx_22050612_mem_responder_if b1 ();
  ysyx_22050612_mem_responder_if b4 ();

`define HOOK(K, B) \
  assign B.req_valid    = t_req_valid[K]; \
  assign B.req_wen      = t_req_wen[K]; \
  assign B.req_addr     = t_req_addr[K]; \
  assign B.req_wdata    = t_req_wdata[K]; \
  assign B.req_wmask    = t_req_wmask[K]; \
  assign B.resp_ready   = t_resp_ready[K]; \
  assign o_req_ready[K]  = B.req_ready; \
  assign o_resp_valid[K] = B.resp_valid; \
  assign o_resp_rdata[K] = B.resp_rdata; \
  assign o_resp_err[K]   = B.resp_err;

  `HOOK(0, b2)
  `HOOK(1, b1)
  `HOOK(2, b4)

  ysyx_22050612_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2));
  ysyx_22050612_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));
  ysyx_22050612_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(BASE), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4));

  function automatic int lat(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observes every instance on the falling edge, away from the active edge.
  task automatic mon(input int k);
    exp_t e;
    int   a;
    if (rst) begin
      acc_q[k].delete();
      prev_rv[k] = 1'b0;
    end else begin
      if (t_req_valid[k] && o_req_ready[k]) begin
        acc_q[k].push_back(cyc + 1);
        acc_hist[k].push_back(cyc + 1);
      end
      if (o_resp_valid[k] && !prev_rv[k]) begin
        if (acc_q[k].size() == 0) begin
          errors++;
          $error("FAIL resp_without_req dut=%0d", k);
        end else begin
          a = acc_q[k].pop_front();
          check($sformatf("latency_dut%0d", k), 64'(cyc + 1), 64'(a + lat(k)));
        end
      end
      if (o_resp_valid[k] && t_resp_ready[k]) begin
        hs_edge[k] = cyc + 1;
        if (exp_q[k].size() == 0) begin
          errors++;
          $error("FAIL resp_unexpected dut=%0d", k);
        end else begin
          e = exp_q[k].pop_front();
          check($sformatf("rdata_dut%0d", k), o_resp_rdata[k], e.rdata);
          check($sformatf("err_dut%0d", k), 64'(o_resp_err[k]), 64'(e.err));
        end
      end
      prev_rv[k] = o_resp_valid[k];
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  task automatic expect_resp(input int k, input logic [63:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    exp_q[k].push_back(e);
  endtask

  task automatic drive_req(input int k, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask);
    t_req_valid[k] = 1'b1;
    t_req_wen[k]   = wen;
    t_req_addr[k]  = addr;
    t_req_wdata[k] = wdata;
    t_req_wmask[k] = wmask;
  endtask

  task automatic wait_accept(input int k);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (o_req_ready[k]) done = 1'b1;
    end
    @(posedge clk);
    #1;
    t_req_valid[k] = 1'b0;
    if (!done) begin
      errors++;
      $error("FAIL accept_timeout dut=%0d", k);
    end
  endtask

  task automatic wait_drain(input int k);
    for (int i = 0; i < 100 && exp_q[k].size() != 0; i++) @(negedge clk);
    if (exp_q[k].size() != 0) begin
      errors++;
      $error("FAIL drain_timeout dut=%0d pending=%0d", k, exp_q[k].size());
      exp_q[k].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int k, input logic wen, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask,
                     input logic [63:0] exp_rd, input logic exp_err);
    expect_resp(k, exp_rd, exp_err);
    drive_req(k, wen, addr, wdata, wmask);
    wait_accept(k);
    wait_drain(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    for (int k = 0; k < 3; k++) begin
      t_req_valid[k]  = 1'b0;
      t_req_wen[k]    = 1'b0;
      t_req_addr[k]   = '0;
      t_req_wdata[k]  = '0;
      t_req_wmask[k]  = '0;
      t_resp_ready[k] = 1'b1;
      hs_edge[k]      = 0;
      prev_rv[k]      = 1'b0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(o_req_ready[0]), 64'd1);
    check("reset_resp_valid", 64'(o_resp_valid[0]), 64'd0);
    check("reset_resp_rdata", o_resp_rdata[0], 64'd0);
    check("reset_resp_err", 64'(o_resp_err[0]), 64'd0);
    @(posedge clk);
    #1;

    // Full-word write then read back
    txn(0, 1'b1, BASE + 64'h8, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
    txn(0, 1'b0, BASE + 64'h8, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);

    // Single-lane merge into byte 2
    txn(0, 1'b1, BASE + 64'hA, 64'h0000_0000_00AA_0000, 8'h04, 64'd0, 1'b0);
    txn(0, 1'b0, BASE + 64'h8, 64'd0, 8'h00, 64'h1122_3344_55AA_7788, 1'b0);

    // Response backpressure with a second request held waiting
    t_resp_ready[0] = 1'b0;
    expect_resp(0, 64'h1122_3344_55AA_7788, 1'b0);
    drive_req(0, 1'b0, BASE + 64'h8, 64'd0, 8'h00);
    wait_accept(0);
    expect_resp(0, 64'h1122_3344_55AA_7788, 1'b0);
    drive_req(0, 1'b0, BASE + 64'h8, 64'd0, 8'h00);
    for (int i = 0; i < 20 && !o_resp_valid[0]; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_resp_valid", 64'(o_resp_valid[0]), 64'd1);
      check("stall_resp_rdata", o_resp_rdata[0], 64'h1122_3344_55AA_7788);
      check("stall_resp_err", 64'(o_resp_err[0]), 64'd0);
      check("stall_req_ready", 64'(o_req_ready[0]), 64'd0);
    end
    @(posedge clk);
    #1 t_resp_ready[0] = 1'b1;
    wait_accept(0);
    check("accept_after_handshake", 64'(acc_hist[0][$]), 64'(hs_edge[0] + 1));
    wait_drain(0);

    // Window boundaries
    txn(0, 1'b1, BASE, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'd0, 1'b0);
    txn(0, 1'b1, 64'h7FFF_FFF8, 64'h0000_0000_0000_DEAD, 8'hFF, 64'd0, 1'b1);
    txn(0, 1'b1, TOP, 64'h0000_0000_0000_DEAD, 8'hFF, 64'd0, 1'b1);
    txn(0, 1'b0, TOP, 64'd0, 8'h00, 64'd0, 1'b1);
    txn(0, 1'b0, BASE, 64'd0, 8'h00, 64'hCAFE_F00D_1234_5678, 1'b0);
    txn(0, 1'b1, TOP - 64'h8, 64'h0BAD_BEEF_0000_0001, 8'hFF, 64'd0, 1'b0);
    txn(0, 1'b0, TOP - 64'h8, 64'd0, 8'h00, 64'h0BAD_BEEF_0000_0001, 1'b0);

    // Reset while a write is pending must drop it
    txn(0, 1'b1, BASE + 64'h10, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 64'd0, 1'b0);
    drive_req(0, 1'b1, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wait_accept(0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_resp_valid", 64'(o_resp_valid[0]), 64'd0);
    check("post_reset_req_ready", 64'(o_req_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    txn(0, 1'b0, BASE + 64'h10, 64'd0, 8'h00, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);

    // Back-to-back reads at LATENCY 1 and 4
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        d = {32'(k), 32'(i)} ^ 64'hF0E1_D2C3_0000_0000;
        txn(k, 1'b1, BASE + 64'(8 * i), d, 8'hFF, 64'd0, 1'b0);
      end
      acc_hist[k].delete();
      for (int i = 0; i < 4; i++) begin
        d = {32'(k), 32'(i)} ^ 64'hF0E1_D2C3_0000_0000;
        expect_resp(k, d, 1'b0);
        drive_req(k, 1'b0, BASE + 64'(8 * i), 64'd0, 8'h00);
        wait_accept(k);
      end
      wait_drain(k);
      check($sformatf("stream_count_dut%0d", k), 64'(acc_hist[k].size()), 64'd4);
      for (int j = 1; j < acc_hist[k].size(); j++) begin
        check($sformatf("stream_period_dut%0d", k),
              64'(acc_hist[k][j] - acc_hist[k][j-1]), 64'(lat(k) + 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_mem_responder.md
Name: ysyx_22050612_mem_responder

Overview:
Memory-side responder for the core's load/store initiator. It accepts one 64-bit-aligned read or byte-masked write request over a valid/ready channel and holds it in a word-addressed internal array. After a fixed, programmable latency it returns the response over a second valid/ready channel. It replaces the zero-latency DPI memory path, so the LSU/EXU can be exercised against real handshakes and backpressure.

Parameters:
DEPTH_LOG2, 10, log2 of the number of 64-bit words in the array
BASE_ADDR, 64'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  core clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_wen  input  1  1 = write, 0 = read
req_addr  input  64  byte address; bits [2:0] ignored for indexing
req_wdata  input  64  write data, already lane-aligned by the requester
req_wmask  input  8  byte-lane enables; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  64  full 64-bit read word; 0 for writes and errors
resp_err  output  1  address fell outside the array window

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not cleared.
- Reset mid-transaction: the pending request is dropped and no write is committed. The cycle after reset, req_ready=1 and resp_valid=0.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register wen, addr, wdata, wmask and load counter=LATENCY-1.
  - Counter==0 at acceptance → go to RESP and perform the access on that edge.
  - Otherwise → go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter reaches 0, perform the access on that edge and go to RESP.
- Timing: if the request is accepted on edge t, resp_valid is high from edge t+LATENCY.
- Access:
  - Word index = (addr - BASE_ADDR) >> 3.
  - Range check: out of range when addr < BASE_ADDR or addr >= BASE_ADDR + 8<<DEPTH_LOG2.
  - Out of range: no array update, resp_err=1, resp_rdata=0.
  - Write: merge each lane with wmask[i]=1. wmask=0 leaves the word unchanged but still produces a response. resp_rdata=0.
  - Read: resp_rdata is the whole stored word. Byte selection and sign/zero extension are the requester's job.
- RESP: req_ready=0. resp_valid, resp_rdata and resp_err stay stable until resp_valid&&resp_ready. On that handshake, clear resp_valid and resp_err and return to IDLE.
  - A new request can be accepted at the earliest one cycle after the response handshake.
  - Peak throughput is one transaction per LATENCY+1 cycles.
- Single outstanding transaction. While req_ready=0, req_valid is ignored; the requester must hold its request until it is accepted.
- A read issued after a write completes returns the written data; there is no bypass hazard because only one transaction is outstanding.
- Accesses that straddle two words are not supported. The requester splits them; the responder only ever touches one word.

Decomposition:
- Shared package ysyx_22050612_mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - constants: WORD_BYTES=8, MASK_W=8, DATA_W=64, ADDR_W=64
- Sub-module ysyx_22050612_mem_array: synchronous single-port byte-masked RAM.
  - Ports: clk, en, we, idx, wdata, wmask, rdata.
  - Registered read.
  - The FSM, counter and range check stay in the top level.

Test Plan:
1. Write at addr 0x8000_0008, wdata 0x1122334455667788, wmask 0xFF, then read the same address → write response rdata=0, err=0; read rdata=0x1122334455667788. With LATENCY=2, resp_valid rises exactly 2 cycles after each acceptance.
2. After test 1, write wdata 0x0000_0000_00AA_0000 with wmask 0x04 to 0x8000_000A, then read 0x8000_0008 → rdata=0x1122334455AA7788.
3. Read with resp_ready held low for 5 cycles while a second req_valid is held → resp_valid, rdata and err stay stable and req_ready=0. The second request is accepted only in the cycle after the handshake.
4. Write 0xDEAD to 0x7FFF_FFF8, then to BASE+8<<DEPTH_LOG2 → resp_err=1 and rdata=0 both times. A read of 0x8000_0000 afterwards shows the previous contents, unchanged.
5. Write accepted, then rst=1 during WAIT → the next cycle shows resp_valid=0 and req_ready=1. A read of that address returns the old value.
6. Back-to-back reads with req_valid and resp_ready held high, LATENCY=1 and LATENCY=4 → one response every 2 and 5 cycles respectively, with correct data for each.
